// File: rtl/pip_pkg.sv
// ----------------------------------------------------------------------------
// pip_pkg
//  Shared types and constants for the pipeline hazard controller.
//  - pip_state_e : sequencer state (RUN / MEM_WAIT / HALT)
//  - FWD_*       : EX operand forwarding select encodings
//  - pip_en_t    : bundle of pipeline register load enables
// ----------------------------------------------------------------------------
package pip_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } pip_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } pip_en_t;

    localparam pip_en_t EN_ALL  = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b1};
    localparam pip_en_t EN_NONE = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0, exmem: 1'b0, memwb: 1'b0};

endpackage

// File: rtl/pip_fwd_unit.sv
// ----------------------------------------------------------------------------
// pip_fwd_unit
//  Combinational forwarding select for one EX-stage source operand.
//  Ports:
//    rs_ad_i      EX-stage source register address
//    mem_rd_ad_i  MEM-stage destination address, mem_rdEn_i its write enable
//    wb_rd_ad_i   WB-stage destination address,  wb_rdEn_i its write enable
//    sel_o        FWD_MEM / FWD_WB / FWD_RF
//  The MEM result is younger than the WB result, so it wins when both match.
//  x0 is hardwired zero and is never forwarded.
// ----------------------------------------------------------------------------
module pip_fwd_unit
    import pip_pkg::*;
(
    input  logic [4:0] rs_ad_i,
    input  logic [4:0] mem_rd_ad_i,
    input  logic       mem_rdEn_i,
    input  logic [4:0] wb_rd_ad_i,
    input  logic       wb_rdEn_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (mem_rdEn_i && (mem_rd_ad_i != 5'd0) && (mem_rd_ad_i == rs_ad_i))
            sel_o = FWD_MEM;
        else if (wb_rdEn_i && (wb_rd_ad_i != 5'd0) && (wb_rd_ad_i == rs_ad_i))
            sel_o = FWD_WB;
    end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pip_hazard_ctrl
//  Pipeline sequencer for the 5-stage core: drives PC and pipeline register
//  enables/flushes, resolves load-use stalls, taken-branch flushes and data
//  memory wait states, and produces EX forwarding selects.
//  Ports:
//    clk, rst_n                 clock, async active-low reset
//    id_rs*_ad, ex_rs*_ad       ID / EX source addresses
//    ex_rd_ad/ex_rdEn/ex_memRd  EX destination, write enable, load flag
//    ex_br_taken                branch/jump in EX resolved taken
//    mem_rd_ad/mem_rdEn         MEM destination and write enable
//    wb_rd_ad/wb_rdEn           WB destination and write enable
//    mem_req/mem_ready          data memory handshake
//    pc_en..memwb_en            pipeline load enables
//    ifid_flush/idex_flush      insert NOP / bubble
//    fwdA_sel/fwdB_sel          EX operand forwarding selects
//    mem_err                    wait watchdog fired (sticky)
//    stall_cnt/flush_cnt        saturating performance counters
//  All control outputs are combinational from state and current inputs and
//  are forced inactive while rst_n is low.
// ----------------------------------------------------------------------------
module pip_hazard_ctrl
    import pip_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_ad,
    input  logic [4:0]       id_rs2_ad,
    input  logic [4:0]       ex_rs1_ad,
    input  logic [4:0]       ex_rs2_ad,
    input  logic [4:0]       ex_rd_ad,
    input  logic             ex_rdEn,
    input  logic             ex_memRd,
    input  logic             ex_br_taken,
    input  logic [4:0]       mem_rd_ad,
    input  logic             mem_rdEn,
    input  logic [4:0]       wb_rd_ad,
    input  logic             wb_rdEn,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic [1:0]       fwdA_sel,
    output logic [1:0]       fwdB_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    pip_state_e         state_q,     state_d;
    logic [WCNT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic               mem_err_q,   mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    pip_en_t            en_c;
    logic               ifid_flush_c, idex_flush_c;
    logic               advance_c;     // pipeline not frozen this cycle
    logic               load_use_c;
    logic               mem_done_c;
    logic [1:0]         fwdA_c, fwdB_c;

    assign load_use_c = ex_memRd && ex_rdEn && (ex_rd_ad != 5'd0) &&
                        ((ex_rd_ad == id_rs1_ad) || (ex_rd_ad == id_rs2_ad));

    // Dropping the request mid-wait releases the pipeline just like ready.
    assign mem_done_c = mem_ready || !mem_req;

    // ---------------- next-state and enable/flush decode ----------------
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = mem_err_q;
        en_c         = EN_ALL;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        advance_c    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    en_c       = EN_NONE;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end else begin
                    advance_c = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_done_c) begin
                    advance_c  = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_MAX) begin
                    en_c      = EN_NONE;
                    state_d   = ST_HALT;
                    mem_err_d = 1'b1;
                end else begin
                    en_c       = EN_NONE;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_HALT: begin
                en_c = EN_NONE;
            end
            default: begin
                en_c    = EN_NONE;
                state_d = ST_HALT;
            end
        endcase

        // A taken branch squashes the younger instructions, so a load-use
        // stall on the (wrong-path) ID instruction is pointless.
        if (advance_c) begin
            if (ex_br_taken) begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
            end else if (load_use_c) begin
                en_c.pc      = 1'b0;
                en_c.ifid    = 1'b0;
                idex_flush_c = 1'b1;
            end
        end
    end

    // ---------------- performance counters (saturating) ----------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!en_c.pc && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (advance_c && ex_br_taken && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ---------------- forwarding ----------------
    pip_fwd_unit u_fwd_a (
        .rs_ad_i     (ex_rs1_ad),
        .mem_rd_ad_i (mem_rd_ad),
        .mem_rdEn_i  (mem_rdEn),
        .wb_rd_ad_i  (wb_rd_ad),
        .wb_rdEn_i   (wb_rdEn),
        .sel_o       (fwdA_c)
    );

    pip_fwd_unit u_fwd_b (
        .rs_ad_i     (ex_rs2_ad),
        .mem_rd_ad_i (mem_rd_ad),
        .mem_rdEn_i  (mem_rdEn),
        .wb_rd_ad_i  (wb_rd_ad),
        .wb_rdEn_i   (wb_rdEn),
        .sel_o       (fwdB_c)
    );

    // ---------------- outputs, held inactive during reset ----------------
    assign pc_en      = rst_n && en_c.pc;
    assign ifid_en    = rst_n && en_c.ifid;
    assign idex_en    = rst_n && en_c.idex;
    assign exmem_en   = rst_n && en_c.exmem;
    assign memwb_en   = rst_n && en_c.memwb;
    assign ifid_flush = rst_n && ifid_flush_c;
    assign idex_flush = rst_n && idex_flush_c;
    assign fwdA_sel   = rst_n ? fwdA_c : FWD_RF;
    assign fwdB_sel   = rst_n ? fwdB_c : FWD_RF;
    assign mem_err    = mem_err_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pip_hazard_ctrl
//  Directed bench. dut uses MEM_TIMEOUT=4 for the watchdog scenario; dut64
//  shares all inputs with the default timeout so a reset can be applied while
//  it is still deep inside a memory wait.
// ----------------------------------------------------------------------------
module tb_pip_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1_ad, id_rs2_ad, ex_rs1_ad, ex_rs2_ad, ex_rd_ad;
    logic       ex_rdEn, ex_memRd, ex_br_taken;
    logic [4:0] mem_rd_ad, wb_rd_ad;
    logic       mem_rdEn, wb_rdEn, mem_req, mem_ready;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic [1:0]  fwdA_sel, fwdB_sel;
    logic        mem_err;
    logic [15:0] stall_cnt, flush_cnt;

    logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush, b_exmem_en, b_memwb_en;
    logic [1:0]  b_fwdA_sel, b_fwdB_sel;
    logic        b_mem_err;
    logic [15:0] b_stall_cnt, b_flush_cnt;

    logic [4:0] en5, b_en5;
    logic [1:0] fl2, b_fl2;
    assign en5   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    assign fl2   = {ifid_flush, idex_flush};
    assign b_en5 = {b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_memwb_en};
    assign b_fl2 = {b_ifid_flush, b_idex_flush};

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pip_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_ad(id_rs1_ad), .id_rs2_ad(id_rs2_ad),
        .ex_rs1_ad(ex_rs1_ad), .ex_rs2_ad(ex_rs2_ad),
        .ex_rd_ad(ex_rd_ad), .ex_rdEn(ex_rdEn), .ex_memRd(ex_memRd),
        .ex_br_taken(ex_br_taken),
        .mem_rd_ad(mem_rd_ad), .mem_rdEn(mem_rdEn),
        .wb_rd_ad(wb_rd_ad), .wb_rdEn(wb_rdEn),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pip_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_ad(id_rs1_ad), .id_rs2_ad(id_rs2_ad),
        .ex_rs1_ad(ex_rs1_ad), .ex_rs2_ad(ex_rs2_ad),
        .ex_rd_ad(ex_rd_ad), .ex_rdEn(ex_rdEn), .ex_memRd(ex_memRd),
        .ex_br_taken(ex_br_taken),
        .mem_rd_ad(mem_rd_ad), .mem_rdEn(mem_rdEn),
        .wb_rd_ad(wb_rd_ad), .wb_rdEn(wb_rdEn),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
        .idex_en(b_idex_en), .idex_flush(b_idex_flush),
        .exmem_en(b_exmem_en), .memwb_en(b_memwb_en),
        .fwdA_sel(b_fwdA_sel), .fwdB_sel(b_fwdB_sel),
        .mem_err(b_mem_err), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1_ad = 5'd0; id_rs2_ad = 5'd0; ex_rs1_ad = 5'd0; ex_rs2_ad = 5'd0;
        ex_rd_ad = 5'd0; ex_rdEn = 1'b0; ex_memRd = 1'b0; ex_br_taken = 1'b0;
        mem_rd_ad = 5'd0; mem_rdEn = 1'b0; wb_rd_ad = 5'd0; wb_rdEn = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        idle();
        rst_n = 1'b0;
        ex_rs1_ad = 5'd7; mem_rd_ad = 5'd7; mem_rdEn = 1'b1;
        #2;
        chk("rst_en",        32'(en5),       32'h00);
        chk("rst_flush",     32'(fl2),       32'h0);
        chk("rst_fwdA",      32'(fwdA_sel),  32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        chk("rst_mem_err",   32'(mem_err),   32'h0);
        chk("rst_b_en",      32'(b_en5),     32'h00);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        #1;
        chk("run_idle_en",   32'(en5),       32'h1f);
        chk("run_idle_fl",   32'(fl2),       32'h0);
        tick();
        #1;
        chk("run_stall0",    32'(stall_cnt), 32'h0);

        // ---------------- load-use on rs1 ----------------
        ex_memRd = 1'b1; ex_rdEn = 1'b1; ex_rd_ad = 5'd5; id_rs1_ad = 5'd5;
        #1;
        chk("lu_rs1_en",     32'(en5),       32'h07);
        chk("lu_rs1_fl",     32'(fl2),       32'h1);
        tick();
        idle();
        #1;
        chk("lu_after_en",   32'(en5),       32'h1f);
        chk("lu_after_fl",   32'(fl2),       32'h0);
        chk("lu_stall_cnt",  32'(stall_cnt), 32'h1);
        tick();

        // ---------------- load-use on rs2 ----------------
        ex_memRd = 1'b1; ex_rdEn = 1'b1; ex_rd_ad = 5'd9; id_rs1_ad = 5'd3; id_rs2_ad = 5'd9;
        #1;
        chk("lu_rs2_en",     32'(en5),       32'h07);
        tick();
        idle();

        // ---------------- no stall: rd = x0, or load without rdEn ----------------
        ex_memRd = 1'b1; ex_rdEn = 1'b1; ex_rd_ad = 5'd0; id_rs1_ad = 5'd0;
        #1;
        chk("lu_x0_en",      32'(en5),       32'h1f);
        chk("lu_x0_fl",      32'(fl2),       32'h0);
        ex_rdEn = 1'b0; ex_rd_ad = 5'd5; id_rs1_ad = 5'd5;
        #1;
        chk("lu_nordEn_en",  32'(en5),       32'h1f);
        tick();
        idle();
        #1;
        chk("lu_x0_stall",   32'(stall_cnt), 32'h2);

        // ---------------- branch + load-use same cycle ----------------
        ex_memRd = 1'b1; ex_rdEn = 1'b1; ex_rd_ad = 5'd5; id_rs1_ad = 5'd5; ex_br_taken = 1'b1;
        #1;
        chk("br_lu_en",      32'(en5),       32'h1f);
        chk("br_lu_fl",      32'(fl2),       32'h3);
        tick();
        idle();
        #1;
        chk("br_flush_cnt",  32'(flush_cnt), 32'h1);
        chk("br_stall_cnt",  32'(stall_cnt), 32'h2);

        // ---------------- memory wait 3 cycles ----------------
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        chk("mw_c1_en",      32'(en5),       32'h00);
        chk("mw_c1_fl",      32'(fl2),       32'h0);
        tick();
        ex_br_taken = 1'b1;
        #1;
        chk("mw_c2_en",      32'(en5),       32'h00);
        chk("mw_frozen_br",  32'(fl2),       32'h0);
        tick();
        ex_br_taken = 1'b0;
        #1;
        chk("mw_c3_en",      32'(en5),       32'h00);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("mw_done_en",    32'(en5),       32'h1f);
        chk("mw_stall_cnt",  32'(stall_cnt), 32'h5);
        tick();
        idle();
        #1;
        chk("mw_run_en",     32'(en5),       32'h1f);
        chk("mw_flush_cnt",  32'(flush_cnt), 32'h1);
        chk("mw_stall_hold", 32'(stall_cnt), 32'h5);
        tick();

        // ---------------- request drop ends the wait ----------------
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        chk("drop_c1_en",    32'(en5),       32'h00);
        tick();
        mem_req = 1'b0;
        #1;
        chk("drop_done_en",  32'(en5),       32'h1f);
        tick();
        idle();
        #1;
        chk("drop_stall",    32'(stall_cnt), 32'h6);

        // ---------------- forwarding ----------------
        ex_rs1_ad = 5'd7; ex_rs2_ad = 5'd0;
        mem_rd_ad = 5'd7; mem_rdEn = 1'b1; wb_rd_ad = 5'd7; wb_rdEn = 1'b1;
        #1;
        chk("fwdA_mem",      32'(fwdA_sel),  32'h2);
        chk("fwdB_x0",       32'(fwdB_sel),  32'h0);
        mem_rdEn = 1'b0;
        #1;
        chk("fwdA_wb",       32'(fwdA_sel),  32'h1);
        ex_rs2_ad = 5'd7;
        #1;
        chk("fwdB_wb",       32'(fwdB_sel),  32'h1);
        mem_rdEn = 1'b1; mem_rd_ad = 5'd3;
        #1;
        chk("fwdA_mem_miss", 32'(fwdA_sel),  32'h1);
        wb_rdEn = 1'b0;
        #1;
        chk("fwdA_none",     32'(fwdA_sel),  32'h0);
        tick();
        idle();

        // ---------------- watchdog timeout (dut MEM_TIMEOUT=4) ----------------
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        chk("to_c1_en",      32'(en5),       32'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_wait_en",   32'(en5),    32'h00);
            chk("to_wait_err",  32'(mem_err), 32'h0);
            tick();
        end
        #1;
        chk("to_halt_err",   32'(mem_err),   32'h1);
        chk("to_halt_en",    32'(en5),       32'h00);
        chk("to_halt_stall", 32'(stall_cnt), 32'd11);
        chk("to_b_wait_en",  32'(b_en5),     32'h00);
        mem_ready = 1'b1; ex_br_taken = 1'b1;
        #1;
        chk("halt_ready_en", 32'(en5),       32'h00);
        chk("halt_br_fl",    32'(fl2),       32'h0);
        chk("b_done_en",     32'(b_en5),     32'h1f);
        chk("b_done_fl",     32'(b_fl2),     32'h3);
        tick();
        idle();
        ex_rs1_ad = 5'd7; mem_rd_ad = 5'd7; mem_rdEn = 1'b1;
        #1;
        chk("halt_fwdA",     32'(fwdA_sel),  32'h2);
        chk("halt_en2",      32'(en5),       32'h00);
        tick();
        tick();
        #1;
        chk("halt_err_sticky", 32'(mem_err),   32'h1);
        chk("halt_en3",        32'(en5),       32'h00);
        chk("halt_stall_cnt",  32'(stall_cnt), 32'd14);
        chk("halt_flush_cnt",  32'(flush_cnt), 32'h1);

        // ---------------- reset leaves HALT ----------------
        rst_n = 1'b0;
        #1;
        chk("halt_rst_en",   32'(en5),       32'h00);
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        chk("post_rst_en",    32'(en5),       32'h1f);
        chk("post_rst_stall", 32'(stall_cnt), 32'h0);
        chk("post_rst_flush", 32'(flush_cnt), 32'h0);
        chk("post_rst_err",   32'(mem_err),   32'h0);
        tick();

        // ---------------- reset mid-MEM_WAIT (dut64, wait_cnt=5) ----------------
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        chk("b_mw_c1_en",    32'(b_en5),     32'h00);
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("b_mw_c6_en",    32'(b_en5),     32'h00);
        // Request dropped together with reset: only reset keeps enables low.
        idle();
        rst_n = 1'b0;
        #1;
        chk("b_rst_mid_en",  32'(b_en5),     32'h00);
        chk("b_rst_mid_fl",  32'(b_fl2),     32'h0);
        chk("rst_mid_en",    32'(en5),       32'h00);
        tick();
        rst_n = 1'b1;
        #1;
        chk("b_rel_en",      32'(b_en5),       32'h1f);
        chk("b_rel_stall",   32'(b_stall_cnt), 32'h0);
        chk("b_rel_flush",   32'(b_flush_cnt), 32'h0);
        chk("b_rel_err",     32'(b_mem_err),   32'h0);
        chk("rel_err",       32'(mem_err),     32'h0);
        mem_req = 1'b1;
        #1;
        chk("b_rel_req_en",  32'(b_en5),       32'h00);
        tick();
        idle();
        #1;
        chk("b_rel_stall1",  32'(b_stall_cnt), 32'h1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
